frame_pipe_sched: RTL and testbench
===================================

FRAME_PIPE_SCHED -- requirements
Module: frame_pipe_sched

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 20'd400000, the maximum cycles any stage may stay in RUN.
REQ-002 SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port StartSignal, input, 1, one-cycle pulse meaning a new input frame is available.
REQ-005 SHALL have ports HistFlag, EquFlag and OutputFlag, input, 1 each, one-cycle stage-done pulses.
REQ-006 SHALL have ports HistControl, EquControl and OutputControl, output, 2 each: 00 idle, 01 start, 10 run, 11 abort.
REQ-007 SHALL have ports HistBank, EquBank and OutputBank, output, 1 each, the ping-pong scratch bank used by each stage.
REQ-008 SHALL have port StartDropped, output, 1, one-cycle pulse when a StartSignal is discarded.
REQ-009 SHALL have port FrameCount, output, 8, count of completed frames.
REQ-010 SHALL have port GlobalFlag, output, 2: 00 idle, 01 busy, 10 frame done, 11 error.

Function
REQ-011 SHALL sequence three stages (Hist -> Equ -> Output) over two scratch banks, with at most two frames in flight.
REQ-012 SHALL run one FSM per stage: IDLE -> START (1 cycle, Control=01) -> RUN (Control=10) -> IDLE; Control=00 in IDLE.
REQ-013 SHALL latch StartSignal into a 1-deep pending bit; a StartSignal while pending is set SHALL be dropped and pulse StartDropped in the following cycle.
REQ-014 SHALL start Hist when pending is set, Hist is IDLE and bank HistBank is unoccupied; the start clears pending, marks the bank occupied and sets Control=01 on the next edge.
REQ-015 SHALL toggle HistBank after each Hist start, beginning at bank 0 after reset.
REQ-016 SHALL honour a stage flag only in RUN and ignore it in IDLE or START.
REQ-017 SHALL, on a flag in RUN, return that stage to IDLE on the next edge and set a handoff token (valid+bank) for the downstream stage.
REQ-018 SHALL start Equ or Output in START in the cycle its handoff token is valid and it is IDLE (one-cycle handoff), copy the token bank to its Bank output and clear the token.
REQ-019 SHALL, on OutputFlag in RUN, clear occupancy of OutputBank, increment FrameCount (255 wraps to 0) and drive GlobalFlag=10 for one cycle.
REQ-020 SHALL sample occupancy as registered state: when a bank is freed in the same cycle Hist waits on it, Hist starts one cycle later.
REQ-021 SHALL drive GlobalFlag by priority: 11 sticky error, then 10 done pulse, then 01 (pending, any token, or any stage non-IDLE), else 00.
REQ-022 SHALL give each stage a RUN cycle counter cleared on entry; on reaching TimeoutCycles, all three Controls SHALL be 11 for exactly one cycle, then all FSMs, tokens, pending and occupancy clear and the error stays latched.
REQ-023 SHALL, while the error is latched, ignore StartSignal without pulsing StartDropped and keep all Controls at 00.
REQ-024 SHALL keep Bank outputs stable from START through RUN of each stage.

Reset
REQ-025 SHALL, on reset, drive all Controls to 00, all Banks to 0, StartDropped 0, FrameCount 0 and GlobalFlag 00, and clear pending, tokens, occupancy, counters and error.
REQ-026 SHALL make reset override every event in the same cycle, including a stage abort in progress.

Structure
REQ-027 SHALL take the Control encodings (IDLE/START/RUN/ABORT) and GlobalFlag encodings from the shared package hist_pkg.
REQ-028 SHALL implement the per-stage FSM and watchdog as sub-module stage_seq, instantiated three times; occupancy, tokens and flags stay in frame_pipe_sched.

Verification
REQ-029 Single frame: StartSignal at cycle 0 -> HistControl=01 at cycle 1, 10 from cycle 2; HistFlag at cycle 10 -> EquControl=01 at cycle 11; OutputFlag later -> GlobalFlag=10 for 1 cycle and FrameCount=1.
REQ-030 Overlap: two StartSignals 3 cycles apart -> second Hist start uses HistBank=1 while Equ runs bank 0; a third StartSignal before bank 0 is freed stays pending and starts the cycle after the freeing OutputFlag plus one.
REQ-031 Drop: StartSignal on two consecutive cycles while Hist is busy -> exactly one StartDropped pulse.
REQ-032 Timeout: TimeoutCycles=16 and EquFlag withheld -> all Controls=11 for exactly 1 cycle after 16 RUN cycles, then 00; GlobalFlag held at 11; StartSignal ignored until reset.
REQ-033 Spurious flags: HistFlag while Hist is IDLE or in START -> no state change.
REQ-034 Wrap and reset: after 256 frames FrameCount=0; reset asserted mid-RUN -> all outputs at reset values on the next edge.

Source files
------------

// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared control/status encodings for the frame pipeline scheduler
package hist_pkg;

  typedef enum logic [1:0] {
    CTRL_IDLE  = 2'b00,
    CTRL_START = 2'b01,
    CTRL_RUN   = 2'b10,
    CTRL_ABORT = 2'b11
  } ctrl_e;

  typedef enum logic [1:0] {
    GF_IDLE  = 2'b00,
    GF_BUSY  = 2'b01,
    GF_DONE  = 2'b10,
    GF_ERROR = 2'b11
  } gflag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_ABORT
  } stage_state_e;

  // Frame handed from one stage to the next, waiting for the downstream stage.
  typedef struct packed {
    logic valid;
    logic bank;
  } token_t;

  function automatic ctrl_e state_to_ctrl(input stage_state_e s);
    case (s)
      ST_START: return CTRL_START;
      ST_RUN:   return CTRL_RUN;
      ST_ABORT: return CTRL_ABORT;
      default:  return CTRL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/stage_seq.sv
// rtl/stage_seq.sv - one pipeline stage sequencer: IDLE/START/RUN with a RUN watchdog
module stage_seq
  import hist_pkg::*;
#(
  parameter logic [19:0] TimeoutCycles = 20'd400000
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  go,
  input  logic  flag,
  input  logic  abort,
  output ctrl_e control,
  output logic  idle,
  output logic  done,
  output logic  expired
);

  stage_state_e state, state_n;
  logic [19:0]  run_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      run_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == ST_RUN) begin
        run_cnt <= run_cnt + 20'd1;
      end else begin
        run_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_n = state;
    done    = 1'b0;
    expired = 1'b0;
    case (state)
      ST_IDLE: begin
        if (go) state_n = ST_START;
      end
      ST_START: state_n = ST_RUN;
      ST_RUN: begin
        // A flag arriving in the last allowed RUN cycle still completes the stage.
        if (flag) begin
          done    = 1'b1;
          state_n = ST_IDLE;
        end else if (run_cnt == TimeoutCycles - 20'd1) begin
          expired = 1'b1;
          state_n = ST_ABORT;
        end
      end
      ST_ABORT: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
    // Any stage timing out drives every stage through one ABORT cycle together.
    if (abort) state_n = ST_ABORT;
  end

  assign control = state_to_ctrl(state);
  assign idle    = (state == ST_IDLE);

endmodule

// File: rtl/frame_pipe_sched.sv
// rtl/frame_pipe_sched.sv - Hist/Equ/Output three-stage frame scheduler over two ping-pong banks
module frame_pipe_sched
  import hist_pkg::*;
#(
  parameter logic [19:0] TimeoutCycles = 20'd400000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       StartSignal,
  input  logic       HistFlag,
  input  logic       EquFlag,
  input  logic       OutputFlag,
  output logic [1:0] HistControl,
  output logic [1:0] EquControl,
  output logic [1:0] OutputControl,
  output logic       HistBank,
  output logic       EquBank,
  output logic       OutputBank,
  output logic       StartDropped,
  output logic [7:0] FrameCount,
  output logic [1:0] GlobalFlag
);

  ctrl_e      hist_ctrl, equ_ctrl, out_ctrl;
  logic       hist_idle, equ_idle, out_idle;
  logic       hist_done_raw, equ_done_raw, out_done_raw;
  logic       hist_exp, equ_exp, out_exp, any_exp;
  logic       hist_done, equ_done, out_done;
  logic       hist_go, equ_go, out_go;
  logic       pending, err, done_pulse, hist_next;
  logic [1:0] occ, occ_n;
  token_t     equ_tok, out_tok;
  logic       equ_src_bank, out_src_bank;
  gflag_e     gflag;

  stage_seq #(.TimeoutCycles(TimeoutCycles)) u_hist (
    .clock   (clock),
    .reset   (reset),
    .go      (hist_go),
    .flag    (HistFlag),
    .abort   (any_exp),
    .control (hist_ctrl),
    .idle    (hist_idle),
    .done    (hist_done_raw),
    .expired (hist_exp)
  );

  stage_seq #(.TimeoutCycles(TimeoutCycles)) u_equ (
    .clock   (clock),
    .reset   (reset),
    .go      (equ_go),
    .flag    (EquFlag),
    .abort   (any_exp),
    .control (equ_ctrl),
    .idle    (equ_idle),
    .done    (equ_done_raw),
    .expired (equ_exp)
  );

  stage_seq #(.TimeoutCycles(TimeoutCycles)) u_out (
    .clock   (clock),
    .reset   (reset),
    .go      (out_go),
    .flag    (OutputFlag),
    .abort   (any_exp),
    .control (out_ctrl),
    .idle    (out_idle),
    .done    (out_done_raw),
    .expired (out_exp)
  );

  assign any_exp   = hist_exp | equ_exp | out_exp;
  assign hist_done = hist_done_raw & ~any_exp;
  assign equ_done  = equ_done_raw & ~any_exp;
  assign out_done  = out_done_raw & ~any_exp;

  // A fresh StartSignal can launch Hist directly without first landing in pending.
  assign hist_go = (pending | StartSignal) & hist_idle & ~occ[hist_next] & ~err & ~any_exp;

  // Downstream stages take a stored token first, else the frame finishing upstream this cycle.
  assign equ_go       = (equ_tok.valid | hist_done) & equ_idle & ~err & ~any_exp;
  assign equ_src_bank = equ_tok.valid ? equ_tok.bank : HistBank;
  assign out_go       = (out_tok.valid | equ_done) & out_idle & ~err & ~any_exp;
  assign out_src_bank = out_tok.valid ? out_tok.bank : EquBank;

  always_comb begin
    occ_n = occ;
    if (out_done) occ_n[OutputBank] = 1'b0;
    if (hist_go)  occ_n[hist_next]  = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending      <= 1'b0;
      err          <= 1'b0;
      done_pulse   <= 1'b0;
      StartDropped <= 1'b0;
      hist_next    <= 1'b0;
      HistBank     <= 1'b0;
      EquBank      <= 1'b0;
      OutputBank   <= 1'b0;
      occ          <= '0;
      equ_tok      <= '0;
      out_tok      <= '0;
      FrameCount   <= '0;
    end else if (any_exp) begin
      err          <= 1'b1;
      pending      <= 1'b0;
      done_pulse   <= 1'b0;
      StartDropped <= 1'b0;
      occ          <= '0;
      equ_tok      <= '0;
      out_tok      <= '0;
    end else begin
      StartDropped <= StartSignal & pending & ~err;
      if (hist_go) begin
        pending <= 1'b0;
      end else if (StartSignal && !err) begin
        pending <= 1'b1;
      end

      if (hist_go) begin
        HistBank  <= hist_next;
        hist_next <= ~hist_next;
      end
      occ <= occ_n;

      if (hist_done && !(equ_go && !equ_tok.valid)) begin
        equ_tok <= '{valid: 1'b1, bank: HistBank};
      end else if (equ_go) begin
        equ_tok.valid <= 1'b0;
      end
      if (equ_go) EquBank <= equ_src_bank;

      if (equ_done && !(out_go && !out_tok.valid)) begin
        out_tok <= '{valid: 1'b1, bank: EquBank};
      end else if (out_go) begin
        out_tok.valid <= 1'b0;
      end
      if (out_go) OutputBank <= out_src_bank;

      done_pulse <= out_done;
      if (out_done) FrameCount <= FrameCount + 8'd1;
    end
  end

  always_comb begin
    gflag = GF_IDLE;
    if (err) begin
      gflag = GF_ERROR;
    end else if (done_pulse) begin
      gflag = GF_DONE;
    end else if (pending || equ_tok.valid || out_tok.valid ||
                 !hist_idle || !equ_idle || !out_idle) begin
      gflag = GF_BUSY;
    end
  end

  assign HistControl   = hist_ctrl;
  assign EquControl    = equ_ctrl;
  assign OutputControl = out_ctrl;
  assign GlobalFlag    = gflag;

endmodule

// File: tb/tb_frame_pipe_sched.sv
// tb/tb_frame_pipe_sched.sv - directed and randomized checks of frame_pipe_sched
module tb_frame_pipe_sched;

  localparam int MAXC = 16384;
  localparam int NFR  = 259;

  logic       clock = 1'b0;
  logic       reset, StartSignal, HistFlag, EquFlag, OutputFlag;
  logic [1:0] HistControl, EquControl, OutputControl, GlobalFlag;
  logic       HistBank, EquBank, OutputBank, StartDropped;
  logic [7:0] FrameCount;

  int checks = 0;
  int errors = 0;

  // Per-frame schedule: start pulse, go cycles and flag cycles of each stage.
  int a_t[NFR], hg_t[NFR], hf_t[NFR], eg_t[NFR], ef_t[NFR], og_t[NFR], of_t[NFR];
  bit st_in[MAXC], hf_in[MAXC], ef_in[MAXC], of_in[MAXC], sd_x[MAXC], fin[MAXC];
  bit h_run[MAXC], e_run[MAXC], o_run[MAXC];
  logic [1:0] x_hc[MAXC], x_ec[MAXC], x_oc[MAXC], x_gf[MAXC];
  logic       x_hb[MAXC], x_eb[MAXC], x_ob[MAXC];
  logic [7:0] x_fc[MAXC];
  int nfr, horizon;

  frame_pipe_sched #(.TimeoutCycles(20'd16)) dut (
    .clock         (clock),
    .reset         (reset),
    .StartSignal   (StartSignal),
    .HistFlag      (HistFlag),
    .EquFlag       (EquFlag),
    .OutputFlag    (OutputFlag),
    .HistControl   (HistControl),
    .EquControl    (EquControl),
    .OutputControl (OutputControl),
    .HistBank      (HistBank),
    .EquBank       (EquBank),
    .OutputBank    (OutputBank),
    .StartDropped  (StartDropped),
    .FrameCount    (FrameCount),
    .GlobalFlag    (GlobalFlag)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input bit s, input bit h, input bit e, input bit o);
    StartSignal = s;
    HistFlag    = h;
    EquFlag     = e;
    OutputFlag  = o;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_hc"}, 8'(HistControl), 8'h00);
    chk({tag, "_ec"}, 8'(EquControl), 8'h00);
    chk({tag, "_oc"}, 8'(OutputControl), 8'h00);
    chk({tag, "_hb"}, 8'(HistBank), 8'h00);
    chk({tag, "_eb"}, 8'(EquBank), 8'h00);
    chk({tag, "_ob"}, 8'(OutputBank), 8'h00);
    chk({tag, "_sd"}, 8'(StartDropped), 8'h00);
    chk({tag, "_fc"}, FrameCount, 8'h00);
    chk({tag, "_gf"}, 8'(GlobalFlag), 8'h00);
  endtask

  function automatic int max2(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

  // Stage timing from the scheduling rules: a stage launches once its input is ready,
  // it is idle, and (for Hist) the bank last used two frames ago has been released.
  task automatic build_schedule();
    int k;
    for (int c = 0; c < MAXC; c++) begin
      st_in[c] = 0; hf_in[c] = 0; ef_in[c] = 0; of_in[c] = 0; sd_x[c] = 0; fin[c] = 0;
      h_run[c] = 0; e_run[c] = 0; o_run[c] = 0;
      x_hc[c] = 2'b00; x_ec[c] = 2'b00; x_oc[c] = 2'b00; x_gf[c] = 2'b00;
      x_hb[c] = 1'b0; x_eb[c] = 1'b0; x_ob[c] = 1'b0; x_fc[c] = 8'h00;
    end
    nfr = 0;
    for (int i = 0; i < NFR; i++) begin
      a_t[i]  = ((i == 0) ? 0 : hg_t[i-1] + 1) + int'($urandom_range(0, 3));
      hg_t[i] = a_t[i];
      if (i > 0) hg_t[i] = max2(hg_t[i], hf_t[i-1] + 1);
      if (i > 1) hg_t[i] = max2(hg_t[i], of_t[i-2] + 1);
      hf_t[i] = hg_t[i] + 1 + int'($urandom_range(1, 12));
      eg_t[i] = (i > 0) ? max2(hf_t[i], ef_t[i-1] + 1) : hf_t[i];
      ef_t[i] = eg_t[i] + 1 + int'($urandom_range(1, 12));
      og_t[i] = (i > 0) ? max2(ef_t[i], of_t[i-1] + 1) : ef_t[i];
      of_t[i] = og_t[i] + 1 + int'($urandom_range(1, 12));
      if (of_t[i] + 4 >= MAXC) break;
      nfr = i + 1;
    end
    horizon = of_t[nfr-1] + 4;
    for (int i = 0; i < nfr; i++) begin
      logic b;
      b = 1'(i % 2);
      st_in[a_t[i]] = 1;
      for (int c = a_t[i] + 1; c <= hg_t[i]; c++) begin
        if ($urandom_range(0, 3) == 0) begin
          st_in[c]   = 1;
          sd_x[c+1]  = 1;
        end
      end
      hf_in[hf_t[i]] = 1;
      ef_in[ef_t[i]] = 1;
      of_in[of_t[i]] = 1;
      x_hc[hg_t[i]+1] = 2'b01;
      x_ec[eg_t[i]+1] = 2'b01;
      x_oc[og_t[i]+1] = 2'b01;
      for (int c = hg_t[i] + 1; c <= hf_t[i]; c++) x_hb[c] = b;
      for (int c = eg_t[i] + 1; c <= ef_t[i]; c++) x_eb[c] = b;
      for (int c = og_t[i] + 1; c <= of_t[i]; c++) x_ob[c] = b;
      for (int c = hg_t[i] + 2; c <= hf_t[i]; c++) begin x_hc[c] = 2'b10; h_run[c] = 1; end
      for (int c = eg_t[i] + 2; c <= ef_t[i]; c++) begin x_ec[c] = 2'b10; e_run[c] = 1; end
      for (int c = og_t[i] + 2; c <= of_t[i]; c++) begin x_oc[c] = 2'b10; o_run[c] = 1; end
      for (int c = a_t[i] + 1; c <= of_t[i]; c++) x_gf[c] = 2'b01;
    end
    for (int i = 0; i < nfr; i++) begin
      x_gf[of_t[i]+1] = 2'b10;
      fin[of_t[i]+1]  = 1;
    end
    k = 0;
    for (int c = 0; c < horizon; c++) begin
      if (fin[c]) k++;
      x_fc[c] = 8'(k % 256);
      // Flags outside RUN must be ignored by the stage.
      if (!h_run[c] && $urandom_range(0, 7) == 0) hf_in[c] = 1;
      if (!e_run[c] && $urandom_range(0, 7) == 0) ef_in[c] = 1;
      if (!o_run[c] && $urandom_range(0, 7) == 0) of_in[c] = 1;
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0);
    repeat (3) next_cycle();
    @(negedge clock);
    check_idle("reset");

    // Single frame with spurious HistFlag in START and in IDLE.
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      drive(c == 0, c == 1 || c == 10 || c == 13, c == 15, c == 20);
      @(negedge clock);
      chk($sformatf("single_hc@%0d", c), 8'(HistControl),
          (c == 1) ? 8'h01 : (c >= 2 && c <= 10) ? 8'h02 : 8'h00);
      chk($sformatf("single_ec@%0d", c), 8'(EquControl),
          (c == 11) ? 8'h01 : (c >= 12 && c <= 15) ? 8'h02 : 8'h00);
      chk($sformatf("single_oc@%0d", c), 8'(OutputControl),
          (c == 16) ? 8'h01 : (c >= 17 && c <= 20) ? 8'h02 : 8'h00);
      chk($sformatf("single_gf@%0d", c), 8'(GlobalFlag),
          (c == 21) ? 8'h02 : (c >= 1 && c <= 20) ? 8'h01 : 8'h00);
      chk($sformatf("single_fc@%0d", c), FrameCount, (c >= 21) ? 8'h01 : 8'h00);
      next_cycle();
    end

    // Two back-to-back starts while Hist runs: one pends, one drops.
    apply_reset();
    for (int c = 0; c < 10; c++) begin
      drive(c == 0 || c == 3 || c == 4, c == 6, 0, 0);
      @(negedge clock);
      chk($sformatf("drop_sd@%0d", c), 8'(StartDropped), (c == 5) ? 8'h01 : 8'h00);
      if (c == 8) begin
        chk("drop_second_hc", 8'(HistControl), 8'h01);
        chk("drop_second_hb", 8'(HistBank), 8'h01);
      end
      next_cycle();
    end

    // Equ watchdog expiry after 16 RUN cycles, then latched error.
    apply_reset();
    for (int c = 0; c < 31; c++) begin
      drive(c == 0 || c == 25 || c == 26, c == 5, 0, 0);
      @(negedge clock);
      if (c == 22) chk("to_ec_run", 8'(EquControl), 8'h02);
      if (c == 23) begin
        chk("to_hc_abort", 8'(HistControl), 8'h03);
        chk("to_ec_abort", 8'(EquControl), 8'h03);
        chk("to_oc_abort", 8'(OutputControl), 8'h03);
        chk("to_gf_abort", 8'(GlobalFlag), 8'h03);
      end
      if (c >= 24) begin
        chk($sformatf("to_hc@%0d", c), 8'(HistControl), 8'h00);
        chk($sformatf("to_ec@%0d", c), 8'(EquControl), 8'h00);
        chk($sformatf("to_oc@%0d", c), 8'(OutputControl), 8'h00);
        chk($sformatf("to_gf@%0d", c), 8'(GlobalFlag), 8'h03);
        chk($sformatf("to_sd@%0d", c), 8'(StartDropped), 8'h00);
      end
      next_cycle();
    end
    apply_reset();
    @(negedge clock);
    check_idle("err_reset");

    // Reset in the very cycle the watchdog fires overrides the abort.
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      reset = (c == 22);
      drive(c == 0, c == 5, 0, 0);
      @(negedge clock);
      if (c == 23) check_idle("abort_reset");
      next_cycle();
    end
    reset = 1'b0;

    // Randomized pipelined frames against the schedule model (covers FrameCount wrap).
    build_schedule();
    apply_reset();
    for (int c = 0; c < horizon; c++) begin
      drive(st_in[c], hf_in[c], ef_in[c], of_in[c]);
      @(negedge clock);
      chk($sformatf("rand_hc@%0d", c), 8'(HistControl), 8'(x_hc[c]));
      chk($sformatf("rand_ec@%0d", c), 8'(EquControl), 8'(x_ec[c]));
      chk($sformatf("rand_oc@%0d", c), 8'(OutputControl), 8'(x_oc[c]));
      chk($sformatf("rand_gf@%0d", c), 8'(GlobalFlag), 8'(x_gf[c]));
      chk($sformatf("rand_fc@%0d", c), FrameCount, x_fc[c]);
      chk($sformatf("rand_sd@%0d", c), 8'(StartDropped), 8'(sd_x[c]));
      if (x_hc[c] != 2'b00) chk($sformatf("rand_hb@%0d", c), 8'(HistBank), 8'(x_hb[c]));
      if (x_ec[c] != 2'b00) chk($sformatf("rand_eb@%0d", c), 8'(EquBank), 8'(x_eb[c]));
      if (x_oc[c] != 2'b00) chk($sformatf("rand_ob@%0d", c), 8'(OutputBank), 8'(x_ob[c]));
      next_cycle();
    end

    // One more frame, then reset while Hist is in RUN.
    for (int c = 0; c < 5; c++) begin
      reset = (c == 3);
      drive(c == 0, 0, 0, 0);
      @(negedge clock);
      if (c == 1) begin
        chk("midrun_hc", 8'(HistControl), 8'h01);
        chk("midrun_hb", 8'(HistBank), 8'(nfr % 2));
      end
      if (c == 4) check_idle("midrun_reset");
      next_cycle();
    end
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
